vend_input_conditioner: RTL and testbench

//  Upstream input stage of the vending machine top: synchronises and debounces the raw coin buttons and product switches.

---
 rtl/vend_pkg.sv | 13 +
 rtl/vend_debounce_ch.sv | 25 ++
 rtl/vend_input_conditioner.sv | 53 +++++
 tb/tb_vend_input_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: coin constants and button indices shared by the input conditioner and the vending FSM
package vend_pkg;
  localparam int COIN_W = 6;
  localparam int BTN_5C = 0;
  localparam int BTN_10C = 1;
  localparam int BTN_25C = 2;
  localparam logic [COIN_W-1:0] COIN_5C = 6'd5;
  localparam logic [COIN_W-1:0] COIN_10C = 6'd10;
  localparam logic [COIN_W-1:0] COIN_25C = 6'd25;
  function automatic logic [COIN_W-1:0] coin_value_of(input logic [2:0] oh);
    return oh[BTN_5C] ? COIN_5C : oh[BTN_10C] ? COIN_10C : oh[BTN_25C] ? COIN_25C : '0;
  endfunction
endpackage

// File: rtl/vend_debounce_ch.sv
// vend_debounce_ch: one input channel - 2-flop synchroniser, tick-paced debounce counter, level and rising-edge flag
module vend_debounce_ch #(
  parameter int DB_TICKS = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic clk_en,
  input  logic raw,
  output logic lvl,
  output logic rise
);
  localparam int CW = DB_TICKS > 1 ? $clog2(DB_TICKS) : 1;
  logic s1, s2, flip;
  logic [CW-1:0] cnt;
  assign flip = clk_en && (s2 != lvl) && (cnt == CW'(DB_TICKS - 1));
  always_ff @(posedge clk)
    if (clr) {s1, s2, cnt, lvl, rise} <= '0;
    else begin
      s1 <= raw;
      s2 <= s1;
      lvl <= lvl ^ flip;
      rise <= flip & ~lvl;
      cnt <= (s2 == lvl || flip) ? '0 : cnt + CW'(clk_en);
    end
endmodule

// File: rtl/vend_input_conditioner.sv
// vend_input_conditioner: debounces coin buttons and product switches into single-cycle events.
// Define COIN_QUEUE_EN to hold coin edges that lose arbitration and emit them on later cycles.
module vend_input_conditioner
  import vend_pkg::*;
#(
  parameter int DB_TICKS = 4,
  parameter int N_BTN = 3,
  parameter int N_SW = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clk_en,
  input  logic [N_BTN-1:0]  btn,
  input  logic [N_SW-1:0]   sw,
  output logic [N_BTN-1:0]  coin_pulse,
  output logic [COIN_W-1:0] coin_value,
  output logic [N_SW-1:0]   sel_pulse,
  output logic [N_BTN-1:0]  btn_lvl,
  output logic [N_SW-1:0]   sw_lvl
);
  logic [N_BTN-1:0] btn_rise, cand, pick;
  logic [N_SW-1:0] sw_rise, sel;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    vend_debounce_ch #(.DB_TICKS(DB_TICKS)) u_ch (
      .clk(clk), .clr(clr), .clk_en(clk_en), .raw(btn[i]), .lvl(btn_lvl[i]), .rise(btn_rise[i])
    );
  end
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    vend_debounce_ch #(.DB_TICKS(DB_TICKS)) u_ch (
      .clk(clk), .clr(clr), .clk_en(clk_en), .raw(sw[i]), .lvl(sw_lvl[i]), .rise(sw_rise[i])
    );
  end
`ifdef COIN_QUEUE_EN
  logic [N_BTN-1:0] pend;
  assign cand = btn_rise | pend;
  always_ff @(posedge clk) pend <= clr ? '0 : cand & ~pick;
`else
  assign cand = btn_rise;
`endif
  // x & -x isolates the lowest set bit: fixed priority to the lowest index
  assign pick = cand & (~cand + N_BTN'(1));
  assign sel = sw_rise & (~sw_rise + N_SW'(1));
  always_ff @(posedge clk)
    if (clr) begin
      coin_pulse <= '0;
      coin_value <= '0;
      sel_pulse <= '0;
    end else begin
      coin_pulse <= pick;
      coin_value <= coin_value_of(3'(pick));
      sel_pulse <= sel;
    end
endmodule

// File: tb/tb_vend_input_conditioner.sv
// tb_vend_input_conditioner: directed + random stimulus checked every cycle against a behavioural model
module tb_vend_input_conditioner;
  localparam int DB = 4;
  logic clk = 0, clr = 1, clk_en = 0;
  logic [2:0] btn = 0;
  logic [3:0] sw = 0;
  logic [2:0] coin_pulse, btn_lvl;
  logic [5:0] coin_value;
  logic [3:0] sel_pulse, sw_lvl;
  int checks = 0, errors = 0;
  int ncoin[3], nsel[4];
  int last_val = 0;
  bit armed = 0;
  bit [6:0] h1, h2, ml, evt;
  int run[7];
  bit [2:0] pend, m_coin;
  bit [5:0] m_val;
  bit [3:0] m_sel;

  vend_input_conditioner #(.DB_TICKS(DB), .N_BTN(3), .N_SW(4)) dut (
    .clk(clk), .clr(clr), .clk_en(clk_en), .btn(btn), .sw(sw),
    .coin_pulse(coin_pulse), .coin_value(coin_value), .sel_pulse(sel_pulse),
    .btn_lvl(btn_lvl), .sw_lvl(sw_lvl)
  );

  always #5 clk = ~clk;

  initial begin
    int d;
    d = 0;
    forever begin
      @(negedge clk);
      d = (d + 1) % 10;
      clk_en = (d == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [3:0] lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(1) << i;
    return 0;
  endfunction

  // Model: a level flips once the synced input has disagreed with it for DB consecutive ticks;
  // an event seen at one edge is emitted as a pulse on the following edge.
  always @(posedge clk) begin
    bit [6:0] nevt;
    bit [2:0] cand;
    if (clr) begin
      h1 = 0; h2 = 0; ml = 0; evt = 0; pend = 0;
      m_coin = 0; m_val = 0; m_sel = 0;
      for (int i = 0; i < 7; i++) run[i] = 0;
      armed = 1;
    end else begin
      cand = evt[2:0];
`ifdef COIN_QUEUE_EN
      cand = cand | pend;
`endif
      m_coin = 3'(lowest({1'b0, cand}));
      m_val = m_coin == 3'b001 ? 6'd5 : m_coin == 3'b010 ? 6'd10 : m_coin == 3'b100 ? 6'd25 : 6'd0;
`ifdef COIN_QUEUE_EN
      pend = cand & ~m_coin;
`endif
      m_sel = lowest(evt[6:3]);
      nevt = 0;
      for (int i = 0; i < 7; i++) begin
        if (h2[i] == ml[i]) run[i] = 0;
        else if (clk_en) begin
          run[i]++;
          if (run[i] == DB) begin
            ml[i] = ~ml[i];
            run[i] = 0;
            nevt[i] = ml[i];
          end
        end
      end
      evt = nevt;
      h2 = h1;
      h1 = {sw, btn};
    end
  end

  always @(posedge clk) begin
    #2;
    if (armed) begin
      check("coin_pulse", 32'(coin_pulse), 32'(m_coin));
      check("coin_value", 32'(coin_value), 32'(m_val));
      check("sel_pulse", 32'(sel_pulse), 32'(m_sel));
      check("btn_lvl", 32'(btn_lvl), 32'(ml[2:0]));
      check("sw_lvl", 32'(sw_lvl), 32'(ml[6:3]));
    end
    if (coin_pulse != 0) last_val = int'(coin_value);
    for (int i = 0; i < 3; i++) ncoin[i] += int'(coin_pulse[i]);
    for (int i = 0; i < 4; i++) nsel[i] += int'(sel_pulse[i]);
  end

  initial begin
    int c0, c1, c2, s0, s2;
    bit seen;
    btn = 3'b111;
    repeat (2) @(negedge clk);
    check("reset_coin", 32'(coin_pulse), 0);
    check("reset_val", 32'(coin_value), 0);
    check("reset_sel", 32'(sel_pulse), 0);
    check("reset_lvl", 32'(btn_lvl), 0);
    clr = 0;
    repeat (20) @(negedge clk);
    check("lvl_early", 32'(btn_lvl), 0);
    repeat (40) @(negedge clk);
    check("lvl_up", 32'(btn_lvl), 7);
    btn = 0;
    repeat (80) @(negedge clk);
    c0 = ncoin[0];
    btn = 3'b001;
    repeat (100) @(negedge clk);
    check("held_one_pulse", 32'(ncoin[0] - c0), 1);
    check("held_val5", 32'(last_val), 5);
    btn = 0;
    repeat (80) @(negedge clk);
    c1 = ncoin[1];
    for (int k = 0; k < 4; k++) begin
      btn[1] = ~btn[1];
      repeat (15) @(negedge clk);
    end
    check("bounce_no_pulse", 32'(ncoin[1] - c1), 0);
    btn = 3'b010;
    repeat (100) @(negedge clk);
    check("bounce_then_pulse", 32'(ncoin[1] - c1), 1);
    check("bounce_val10", 32'(last_val), 10);
    btn = 0;
    repeat (80) @(negedge clk);
    c0 = ncoin[0];
    c2 = ncoin[2];
    btn = 3'b101;
    repeat (100) @(negedge clk);
    check("simul_5c", 32'(ncoin[0] - c0), 1);
`ifdef COIN_QUEUE_EN
    check("simul_25c_queued", 32'(ncoin[2] - c2), 1);
    check("simul_last25", 32'(last_val), 25);
`else
    check("simul_25c_dropped", 32'(ncoin[2] - c2), 0);
    check("simul_last5", 32'(last_val), 5);
`endif
    btn = 0;
    repeat (80) @(negedge clk);
    s0 = nsel[0];
    s2 = nsel[2];
    sw = 4'b0101;
    repeat (100) @(negedge clk);
    check("sel_low_wins", 32'(nsel[0] - s0), 1);
    check("sel_dropped", 32'(nsel[2] - s2), 0);
    sw = 4'b0100;
    repeat (100) @(negedge clk);
    check("sel_held_no_rearm", 32'(nsel[2] - s2), 0);
    sw = 0;
    repeat (80) @(negedge clk);
    sw = 4'b0100;
    repeat (100) @(negedge clk);
    check("sel_repress", 32'(nsel[2] - s2), 1);
    sw = 0;
    repeat (80) @(negedge clk);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (clk_en) begin
        seen = 1;
        break;
      end
    end
    check("tick_seen", 32'(seen), 1);
    @(negedge clk);
    c2 = ncoin[2];
    btn = 3'b100;
    repeat (25) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    repeat (20) @(negedge clk);
    check("clr_abandons", 32'(ncoin[2] - c2), 0);
    repeat (60) @(negedge clk);
    check("clr_restart", 32'(ncoin[2] - c2), 1);
    btn = 0;
    repeat (80) @(negedge clk);
    for (int s = 0; s < 300; s++) begin
      btn = 3'($urandom_range(0, 7));
      sw = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      clr = 0;
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
